// File: rtl/maxmin_divider_seq_if.sv
// Handshake bundle between the max/min extraction stage, the divider and the
// saturation/hue multipliers. The divider is the slave on both sides.
interface maxmin_divider_seq_if #(
  parameter int IN_W   = 8,
  parameter int FRAC_W = 16
);
  localparam int Q_W = IN_W + FRAC_W;

  logic              in_valid;
  logic              in_ready;
  logic [IN_W-1:0]   num;
  logic [IN_W:0]     den;
  logic              mode;
  logic              out_valid;
  logic              out_ready;
  logic [Q_W-1:0]    quot;
  logic              div_zero;

  modport master (
    output in_valid, num, den, mode, out_ready,
    input  in_ready, out_valid, quot, div_zero
  );

  modport slave (
    input  in_valid, num, den, mode, out_ready,
    output in_ready, out_valid, quot, div_zero
  );
endinterface

// File: rtl/maxmin_divider_seq.sv
// Radix-2 restoring divider computing floor(num * 2^FRAC_W / divisor), where
// the divisor is the MAX+MIN sum or its mirror 2*MAXV - sum. Constant latency
// of Q_W cycles from accept to out_valid.
//
// state  | meaning
// S_IDLE | waiting for operands
// S_DIV  | one restoring step per cycle, Q_W steps total
// S_DONE | result held on the output until out_ready
module maxmin_divider_seq #(
  parameter int IN_W   = 8,
  parameter int FRAC_W = 16
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  maxmin_divider_seq_if.slave  bus
);
  localparam int Q_W   = IN_W + FRAC_W;
  localparam int CNT_W = $clog2(Q_W);
  localparam logic [IN_W:0]    C_MIRROR = {{IN_W{1'b1}}, 1'b0};
  localparam logic [CNT_W-1:0] C_LAST   = CNT_W'(Q_W - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DIV  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [Q_W-1:0]    r_dvd;
  logic [IN_W:0]     r_divisor;
  logic [IN_W+1:0]   r_rem;
  logic [CNT_W-1:0]  r_cnt;
  logic [Q_W-1:0]    r_quot;
  logic              r_div_zero;

  logic              w_accept;
  logic              w_last;
  logic [IN_W:0]     w_div_eff;
  logic [IN_W+1:0]   w_rem_sh;
  logic [IN_W+1:0]   w_rem_sub;
  logic              w_ge;
  logic [IN_W+1:0]   w_rem_nxt;
  logic [Q_W-1:0]    w_dvd_nxt;

  assign bus.in_ready  = (r_state == S_IDLE) | ((r_state == S_DONE) & bus.out_ready);
  assign bus.out_valid = (r_state == S_DONE);
  assign bus.quot      = r_quot;
  assign bus.div_zero  = r_div_zero;

  assign w_accept = bus.in_valid & bus.in_ready;
  assign w_last   = (r_cnt == C_LAST);

  // Effective divisor; mirror mode clamps to zero instead of wrapping.
  always_comb begin
    w_div_eff = bus.den;
    if (bus.mode) begin
      w_div_eff = (bus.den > C_MIRROR) ? '0 : (C_MIRROR - bus.den);
    end
  end

  // One restoring step. The remainder bit shifted out of the top means the
  // true shifted value exceeds any divisor, so it folds into the compare and
  // the subtract can stay IN_W+2 bits wide (the result is always < divisor).
  always_comb begin
    w_rem_sh  = {r_rem[IN_W:0], r_dvd[Q_W-1]};
    w_rem_sub = w_rem_sh - {1'b0, r_divisor};
    w_ge      = r_rem[IN_W+1] | (w_rem_sh >= {1'b0, r_divisor});
    w_rem_nxt = w_ge ? w_rem_sub : w_rem_sh;
    w_dvd_nxt = {r_dvd[Q_W-2:0], w_ge};
  end

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_reset) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  // Next-state decode.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_state_nxt = S_DIV;
      S_DIV:   if (w_last)   w_state_nxt = S_DONE;
      S_DONE:  if (bus.out_ready) w_state_nxt = bus.in_valid ? S_DIV : S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Operand capture, iteration datapath and result register.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_dvd      <= '0;
      r_divisor  <= '0;
      r_rem      <= '0;
      r_cnt      <= '0;
      r_quot     <= '0;
      r_div_zero <= 1'b0;
    end else if (w_accept) begin
      r_dvd      <= {bus.num, {FRAC_W{1'b0}}};
      r_divisor  <= w_div_eff;
      r_rem      <= '0;
      r_cnt      <= '0;
    end else if (r_state == S_DIV) begin
      r_dvd <= w_dvd_nxt;
      r_rem <= w_rem_nxt;
      r_cnt <= r_cnt + CNT_W'(1);
      if (w_last) begin
        // A zero divisor still runs every step so latency is constant.
        if (r_divisor == '0) begin
          r_quot     <= '0;
          r_div_zero <= 1'b1;
        end else begin
          r_quot     <= w_dvd_nxt;
          r_div_zero <= 1'b0;
        end
      end
    end
  end
endmodule

// File: tb/tb_maxmin_divider_seq.sv
// Randomised and directed bench for maxmin_divider_seq against a plain
// arithmetic reference and a queue of outstanding results.
module tb_maxmin_divider_seq;
  localparam int IN_W   = 8;
  localparam int FRAC_W = 16;
  localparam int Q_W    = IN_W + FRAC_W;
  localparam int DW     = IN_W + 1;
  localparam int MAXV   = (1 << IN_W) - 1;
  localparam int LAT    = Q_W;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  maxmin_divider_seq_if #(.IN_W(IN_W), .FRAC_W(FRAC_W)) bus ();

  maxmin_divider_seq #(.IN_W(IN_W), .FRAC_W(FRAC_W)) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (bus)
  );

  typedef struct {
    int unsigned q;
    bit          dz;
    int          acc;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  bit   post_rst = 0;
  bit   rand_ready = 0;

  function automatic exp_t ref_div(input int unsigned n, input int unsigned d, input bit m);
    exp_t e;
    int unsigned dv;
    if (m) dv = (d > 2 * MAXV) ? 0 : (2 * MAXV - d);
    else   dv = d;
    e.acc = 0;
    if (dv == 0) begin
      e.q  = 0;
      e.dz = 1'b1;
    end else begin
      e.q  = (n * (1 << FRAC_W)) / dv;
      e.dz = 1'b0;
    end
    return e;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Single compare process: everything is sampled on the falling edge.
  always @(negedge clk) begin
    bit   exp_rdy;
    bit   exp_vld;
    exp_t e;
    if (post_rst) begin
      checks++;
      if (bus.out_valid !== 1'b0 || bus.quot !== '0 || bus.div_zero !== 1'b0 || bus.in_ready !== 1'b1) begin
        errors++;
        $display("FAIL reset_state: out_valid=%b quot=%h div_zero=%b in_ready=%b, required 0 000000 0 1",
                 bus.out_valid, bus.quot, bus.div_zero, bus.in_ready);
      end
      post_rst = 0;
    end
    exp_vld = (exp_q.size() > 0) && (cyc >= exp_q[0].acc + LAT);
    if (exp_q.size() == 0) exp_rdy = 1'b1;
    else if (exp_vld)      exp_rdy = bus.out_ready;
    else                   exp_rdy = 1'b0;
    checks++;
    if (bus.in_ready !== exp_rdy) begin
      errors++;
      $display("FAIL in_ready cyc=%0d: got %b, required %b", cyc, bus.in_ready, exp_rdy);
    end
    checks++;
    if (bus.out_valid !== exp_vld) begin
      errors++;
      $display("FAIL out_valid cyc=%0d: got %b, required %b", cyc, bus.out_valid, exp_vld);
      if (exp_vld) void'(exp_q.pop_front());
    end else if (exp_vld) begin
      e = exp_q[0];
      checks++;
      if (32'(bus.quot) !== e.q || bus.div_zero !== e.dz) begin
        errors++;
        $display("FAIL result cyc=%0d: quot=%h div_zero=%b, required quot=%h div_zero=%b",
                 cyc, bus.quot, bus.div_zero, e.q[Q_W-1:0], e.dz);
      end
      if (bus.out_ready && !rst) void'(exp_q.pop_front());
    end
    if (!rst && bus.in_valid && bus.in_ready) begin
      e = ref_div(32'(bus.num), 32'(bus.den), bus.mode);
      e.acc = cyc + 1;
      exp_q.push_back(e);
    end
    if (rst) begin
      exp_q.delete();
      post_rst = 1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_ready) bus.out_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic send(input int unsigned n, input int unsigned d, input bit m);
    bit ok;
    ok = 0;
    bus.num      = IN_W'(n);
    bus.den      = DW'(d);
    bus.mode     = m;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        ok = 1;
        break;
      end
      tick();
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: in_ready stayed 0, required 1 within 200 cycles");
      bus.in_valid = 1'b0;
    end else begin
      tick();
      bus.in_valid = 1'b0;
      bus.num      = IN_W'($urandom);
      bus.den      = DW'($urandom);
      bus.mode     = 1'($urandom);
    end
  endtask

  task automatic drain();
    bit ok;
    ok = 0;
    for (int i = 0; i < 200; i++) begin
      if (exp_q.size() == 0) begin
        ok = 1;
        break;
      end
      tick();
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: %0d results outstanding, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  // Pin the reference model to a hand-computed value, then run the op.
  task automatic run_pinned(input int unsigned n, input int unsigned d, input bit m,
                            input int unsigned lit_q, input bit lit_dz);
    exp_t e;
    e = ref_div(n, d, m);
    checks++;
    if (e.q != lit_q || e.dz != lit_dz) begin
      errors++;
      $display("FAIL model_pin n=%0d d=%0d m=%0d: model %h/%b, required %h/%b",
               n, d, m, e.q, e.dz, lit_q, lit_dz);
    end
    send(n, d, m);
    drain();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running, required finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit ok;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.num       = '0;
    bus.den       = '0;
    bus.mode      = 1'b0;
    bus.out_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    tick();

    // Directed values with out_ready held high.
    bus.out_ready = 1'b1;
    run_pinned(255, 1,   0, 32'hFF0000, 0);
    run_pinned(255, 7,   0, 32'h246DB6, 0);
    run_pinned(255, 255, 0, 32'h010000, 0);
    run_pinned(255, 509, 1, 32'hFF0000, 0);
    run_pinned(255, 255, 1, 32'h010000, 0);
    run_pinned(100, 200, 0, 32'h008000, 0);
    run_pinned(255, 0,   0, 32'h000000, 1);
    run_pinned(255, 510, 1, 32'h000000, 1);
    run_pinned(255, 511, 1, 32'h000000, 1);

    // Backpressure in DONE, then release together with a new accept.
    bus.out_ready = 1'b0;
    send(200, 100, 0);
    ok = 0;
    for (int i = 0; i < 60; i++) begin
      if (bus.out_valid) begin
        ok = 1;
        break;
      end
      tick();
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL backpressure_wait: out_valid stayed 0, required 1");
    end
    repeat (5) tick();
    bus.out_ready = 1'b1;
    run_pinned(255, 3, 0, 32'h550000, 0);

    // Reset in the 10th DIV cycle discards the in-flight operation.
    send(255, 7, 0);
    repeat (9) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    repeat (30) tick();
    run_pinned(100, 200, 0, 32'h008000, 0);

    // Random sweep with random backpressure and idle gaps.
    rand_ready = 1;
    for (int k = 0; k < 150; k++) begin
      repeat ($urandom_range(0, 2)) tick();
      send($urandom_range(0, 255), $urandom_range(0, 511), 1'($urandom_range(0, 1)));
    end
    rand_ready    = 0;
    bus.out_ready = 1'b1;
    drain();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/maxmin_divider_seq.md
# maxmin_divider_seq

Parametrised sequential divider that replaces fixed reciprocal lookup in the HSL conversion path. It computes floor(num · 2^FRAC_W / divisor) with a radix-2 restoring algorithm. The divisor is either the MAX+MIN sum or its mirrored form (2·MAXV − sum) for high-luminance saturation. It sits between the max/min extraction stage and the saturation/hue multipliers, with valid/ready handshakes on both sides and constant latency.

## Interface
- IN_W, 8, channel width; MAXV = 2^IN_W − 1.
- FRAC_W, 16, fractional bits of the quotient.
- Q_W (localparam) = IN_W + FRAC_W, quotient width and iteration count.
- clk  input  1  single clock, rising edge.
- reset  input  1  synchronous, active-high.
- in_valid  input  1  operands present.
- in_ready  output  1  block can accept operands.
- num  input  IN_W  numerator (e.g. max−min, or MAXV for a pure reciprocal).
- den  input  IN_W+1  MAX+MIN sum, 0..2·MAXV+1.
- mode  input  1  0: divisor = den; 1: divisor = 2·MAXV − den.
- out_valid  output  1  result present.
- out_ready  input  1  downstream accepts result.
- quot  output  Q_W  unsigned quotient, FRAC_W fractional bits.
- div_zero  output  1  effective divisor was 0; quot forced to 0.

## Operation
- The FSM has three states: IDLE, DIV and DONE. Reset enters IDLE.
- in_ready = (state==IDLE) | (state==DONE & out_ready).
- Accept occurs on any edge with in_valid & in_ready. At accept the block:
  - latches num·2^FRAC_W as the Q_W-bit dividend;
  - computes the effective divisor (IN_W+1 bits);
  - clears the remainder (IN_W+2 bits) and the iteration counter;
  - enters DIV.
- Mirror mode with den > 2·MAXV gives an effective divisor of 0 (clamp, no wrap).
- Each DIV edge runs one restoring step:
  - remainder = {remainder, dividend MSB}; dividend shifts left;
  - if remainder ≥ divisor, subtract and shift 1 into the quotient, else shift 0.
- After Q_W steps the FSM enters DONE.
- A zero divisor still runs all Q_W steps. On entry to DONE, quot is forced to 0 and div_zero to 1.
- DONE holds quot, div_zero and out_valid=1 stable until out_ready.
- When out_ready is high in DONE:
  - with in_valid also high, new operands are accepted on the same edge and the FSM goes to DIV;
  - otherwise the FSM goes to IDLE.
- Operand changes after accept are ignored.
- Arithmetic is exact floor. No overflow is possible: the maximum result is MAXV·2^FRAC_W < 2^Q_W.
- Reset values: state IDLE, out_valid 0, quot 0, div_zero 0, in_ready 1, internal registers 0.

## Timing
- Latency: out_valid rises exactly Q_W edges after the accept edge (24 for the defaults), independent of operands.
- in_ready is low for the whole of DIV.
- Throughput is one result per Q_W+1 cycles with out_ready held high, since accept happens in DONE.
- Reset during DIV or DONE takes effect on the next edge. The in-flight operation is discarded and no out_valid is produced for it.
- Reset dominates a simultaneous accept.
- out_valid and quot are registered outputs. in_ready is combinational from state and out_ready; there is no combinational in→out path.

## Test plan
- num=255, den=1, mode=0, out_ready=1 → quot=0xFF0000, div_zero=0, out_valid exactly 24 cycles after accept. Repeat with den=7 → 0x246DB6 and den=255 → 0x010000.
- Mirror mode: mode=1, den=509 → quot=0xFF0000. mode=1, den=255 → 0x010000. num=100, mode=0, den=200 → 0x008000.
- Zero divisor: mode=0, den=0 → quot=0, div_zero=1. mode=1, den=510 and den=511 → quot=0, div_zero=1. Latency is still 24 in every case.
- Backpressure: hold out_ready=0 for 5 cycles in DONE → quot and out_valid stable, in_ready=0. Then assert out_ready with in_valid (num=255, den=3) on the same edge → new accept, next result 0x550000.
- Reset at the 10th DIV cycle → next cycle out_valid=0, quot=0, in_ready=1, and no result appears for the aborted operation. A fresh operation afterwards returns the correct value.
- Sweep: random num ∈ 0..255, den ∈ 0..511, mode ∈ {0,1}, random out_ready. Compare each result against a reference floor(num·65536/divisor), or 0 with div_zero set.
